tm_sch_pri_mem_n: RTL and testbench
===================================

// Module: tm_sch_pri_mem_n
// PURPOSE
// - Parametrised N-bank priority-scheduler control memory for the TM scheduler tree; replaces fixed 8-instance wrappers.
// - Holds storage internally; arbitrates per bank between the scheduler read port (app) and PIO read/write.
// - Adds: post-reset zero-init sweep, bounded PIO-read starvation, write->read forwarding, broadcast PIO writes.
// PARAMETERS
// - NUM_BANKS     8                                 number of independent banks (1..16)
// - WIDTH         (`FOURTH_LVL_QUEUE_ID_NBITS<<1)   entry width, <= PIO_NBITS
// - DEPTH_NBITS   `FOURTH_LVL_SCH_ID_NBITS          log2 entries per bank
// - PIO_NBITS     32                                PIO data/address width
// - PIO_MAX_WAIT  4                                 max blocked cycles for a pending PIO read (0 = PIO always wins)
// PORTS
// - clk         in   1                        clock
// - rst_n       in   1                        async active-low reset
// - reg_addr    in   PIO_NBITS                PIO byte address; word index = reg_addr[DEPTH_NBITS+1:2]
// - reg_din     in   PIO_NBITS                PIO write data; bits [WIDTH-1:0] used
// - reg_rd      in   1                        PIO read strobe (1 cycle)
// - reg_wr      in   1                        PIO write strobe (1 cycle)
// - reg_ms      in   NUM_BANKS                PIO bank select; multi-hot allowed for writes
// - app_rd      in   NUM_BANKS                per-bank read request; held until app_ack
// - app_raddr   in   NUM_BANKS*DEPTH_NBITS    per-bank read address, bank b at [b*DEPTH_NBITS +: DEPTH_NBITS]
// - app_ack     out  NUM_BANKS                per-bank read ack, 1-cycle pulse
// - app_rdata   out  NUM_BANKS*WIDTH          per-bank read data, valid with app_ack
// - mem_ack     out  NUM_BANKS                per-bank PIO read ack, 1-cycle pulse
// - mem_rdata   out  NUM_BANKS*PIO_NBITS      per-bank PIO read data, zero-extended, valid with mem_ack
// - init_done   out  1                        high once init sweep is complete
// BEHAVIOUR
// - Reset: all outputs 0; FSM=INIT; init addr, pending flags, wait counters, write stage cleared.
// - FSM INIT: each cycle writes 0 to addr init_cnt in every bank; init_cnt 0..2^DEPTH_NBITS-1; after last addr -> RUN.
// - FSM RUN: init_done=1; stays until reset. In INIT no grants; reg_wr/reg_rd ignored (no ack).
// - PIO write: cycle t reg_wr -> write stage registers {reg_ms, addr, din[WIDTH-1:0]}; bank RAM written end of t+1.
// - Forwarding: app read granted in t+1 to write-stage addr of a selected bank returns new data.
// - PIO read: reg_rd&reg_ms[b] at t -> pend[b]=1 at t+1; reg_rd to a bank already pending ignored.
// - Bank grant per cycle, bank b, pend[b]=1: PIO wins if !app_rd[b] or wait_cnt[b]==PIO_MAX_WAIT; else app wins, wait_cnt[b]++.
// - PIO win: pend[b]<=0, wait_cnt[b]<=0; mem_ack[b]=1 next cycle; app_ack[b] low that cycle, app keeps request.
// - App grant at t -> app_ack[b]=1 and app_rdata at t+1; back-to-back: grant every cycle while app_rd held (throughput 1/cycle).
// - app_rd must drop the cycle after app_ack unless a new read; a held app_rd issues a new read each cycle.
// - Simultaneous PIO write and PIO read on same bank: legal; write stage and read independent; read sees RAM at grant cycle (write visible via forwarding).
// - Addresses wrap modulo 2^DEPTH_NBITS (upper reg_addr bits ignored).
// - Reset mid-operation: pending reads dropped, no acks issued, INIT reruns; RAM contents rewritten to 0.
// - app_rdata/mem_rdata hold last value when ack low.
// TESTING
// - Reset release, DEPTH_NBITS=4: init_done rises 16 cycles after rst_n high; app_rd all addrs, all banks -> rdata 0.
// - reg_wr, reg_ms=0x08, addr 0x14, din 0x1234 -> app read bank3 addr5 returns 0x1234; bank2 addr5 returns 0.
// - reg_wr addr7 data 0xBEEF at t, app_rd bank0 addr7 at t+1 -> app_ack t+2 with 0xBEEF (forwarded).
// - app_rd bank0 held high, reg_rd bank0 at t -> mem_ack t+6 (PIO_MAX_WAIT=4); app_ack low at t+6 only.
// - reg_wr reg_ms=0xFF din 0x55 addr 2 -> app reads addr2 in all 8 banks return 0x55.
// - rst_n low while bank1 PIO read pending -> no mem_ack; init_done drops; after re-init all reads return 0.

Source files
------------

// File: rtl/tm_sch_pri_mem_n.sv
// tm_sch_pri_mem_n: N-bank scheduler control memory arbitrating app reads against PIO read/write,
// with post-reset zero sweep, bounded PIO starvation, write forwarding and broadcast writes.
module tm_sch_pri_mem_n #(
    parameter int NUM_BANKS    = 8,
    parameter int WIDTH        = 16,
    parameter int DEPTH_NBITS  = 4,
    parameter int PIO_NBITS    = 32,
    parameter int PIO_MAX_WAIT = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PIO_NBITS-1:0]             reg_addr,
    input  logic [PIO_NBITS-1:0]             reg_din,
    input  logic                             reg_rd,
    input  logic                             reg_wr,
    input  logic [NUM_BANKS-1:0]             reg_ms,
    input  logic [NUM_BANKS-1:0]             app_rd,
    input  logic [NUM_BANKS*DEPTH_NBITS-1:0] app_raddr,
    output logic [NUM_BANKS-1:0]             app_ack,
    output logic [NUM_BANKS*WIDTH-1:0]       app_rdata,
    output logic [NUM_BANKS-1:0]             mem_ack,
    output logic [NUM_BANKS*PIO_NBITS-1:0]   mem_rdata,
    output logic                             init_done
);
    localparam int WN = $clog2(PIO_MAX_WAIT + 2);
    typedef enum logic {INIT, RUN} state_e;
    state_e                 state_q, state_d;
    logic [DEPTH_NBITS-1:0] init_cnt_q, init_cnt_d, reg_idx, ws_addr_q;
    logic                   ws_vld_q, run, unused_bits;
    logic [NUM_BANKS-1:0]   ws_ms_q;
    logic [WIDTH-1:0]       ws_data_q;
    assign run         = state_q == RUN;
    assign init_done   = run;
    assign reg_idx     = reg_addr[DEPTH_NBITS+1:2];
    assign unused_bits = ^{reg_addr, reg_din};
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (!run) begin
            init_cnt_d = init_cnt_q + 1'b1;
            state_d    = &init_cnt_q ? RUN : INIT;
        end
    end
    // Write stage: one cycle of latency before RAM commit, bridged by forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            ws_vld_q   <= 1'b0;
            ws_ms_q    <= '0;
            ws_addr_q  <= '0;
            ws_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ws_vld_q   <= run && reg_wr;
            if (run && reg_wr) begin
                ws_ms_q   <= reg_ms;
                ws_addr_q <= reg_idx;
                ws_data_q <= reg_din[WIDTH-1:0];
            end
        end
    end
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [WIDTH-1:0]       mem_q [2**DEPTH_NBITS];
        logic                   pend_q, ack_q, mack_q, pio_win, app_win, fwd;
        logic [WN-1:0]          wait_q;
        logic [DEPTH_NBITS-1:0] paddr_q, app_addr, rd_addr;
        logic [WIDTH-1:0]       rd_data, rdata_q;
        logic [PIO_NBITS-1:0]   mdata_q;
        always_comb begin
            app_addr = app_raddr[b*DEPTH_NBITS +: DEPTH_NBITS];
            pio_win  = pend_q && (!app_rd[b] || wait_q == WN'(PIO_MAX_WAIT));
            app_win  = run && app_rd[b] && !pio_win;
            rd_addr  = pio_win ? paddr_q : app_addr;
            fwd      = ws_vld_q && ws_ms_q[b] && ws_addr_q == rd_addr;
            rd_data  = fwd ? ws_data_q : mem_q[rd_addr];
        end
        always_ff @(posedge clk) begin
            if (!run)
                mem_q[init_cnt_q] <= '0;
            else if (ws_vld_q && ws_ms_q[b])
                mem_q[ws_addr_q] <= ws_data_q;
        end
        // A new PIO read is only accepted when the bank has none outstanding.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_q  <= 1'b0;
                paddr_q <= '0;
                wait_q  <= '0;
                ack_q   <= 1'b0;
                mack_q  <= 1'b0;
                rdata_q <= '0;
                mdata_q <= '0;
            end else begin
                pend_q  <= pio_win ? 1'b0 : (pend_q || (run && reg_rd && reg_ms[b]));
                paddr_q <= (!pend_q && reg_rd && reg_ms[b]) ? reg_idx : paddr_q;
                wait_q  <= pio_win ? '0 : (pend_q && app_win) ? wait_q + 1'b1 : wait_q;
                ack_q   <= app_win;
                mack_q  <= pio_win;
                rdata_q <= app_win ? rd_data : rdata_q;
                mdata_q <= pio_win ? PIO_NBITS'(rd_data) : mdata_q;
            end
        end
        assign app_ack[b]                             = ack_q;
        assign mem_ack[b]                             = mack_q;
        assign app_rdata[b*WIDTH +: WIDTH]            = rdata_q;
        assign mem_rdata[b*PIO_NBITS +: PIO_NBITS]    = mdata_q;
    end
endmodule

// File: tb/tb_tm_sch_pri_mem_n.sv
// tb_tm_sch_pri_mem_n: directed and randomized checks of tm_sch_pri_mem_n against a per-bank array model.
module tb_tm_sch_pri_mem_n;
    localparam int NB = 8, W = 16, DN = 4, P = 32, MW = 4, DEP = 16;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [P-1:0]     reg_addr = '0, reg_din = '0;
    logic             reg_rd = 1'b0, reg_wr = 1'b0;
    logic [NB-1:0]    reg_ms = '0, app_rd = '0, app_ack, mem_ack;
    logic [NB*DN-1:0] app_raddr = '0;
    logic [NB*W-1:0]  app_rdata;
    logic [NB*P-1:0]  mem_rdata;
    logic             init_done;
    logic [W-1:0]     mdl [NB][DEP];
    int               pass = 0, total = 0;

    tm_sch_pri_mem_n #(.NUM_BANKS(NB), .WIDTH(W), .DEPTH_NBITS(DN), .PIO_NBITS(P), .PIO_MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd),
        .reg_wr(reg_wr), .reg_ms(reg_ms), .app_rd(app_rd), .app_raddr(app_raddr),
        .app_ack(app_ack), .app_rdata(app_rdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .init_done(init_done));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [P-1:0] obs, input logic [P-1:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [P-1:0] baddr(input int a);
        return ($urandom & ~32'h3F) | P'(a << 2) | P'($urandom % 4);
    endfunction

    task automatic clr_model;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEP; a++) mdl[b][a] = '0;
    endtask

    task automatic wait_init;
        int n = 0;
        while (!init_done && n < 40) begin
            chk("no_ack_in_init", P'({app_ack, mem_ack}), '0);
            step;
            n++;
        end
        chk("init_cycles", n, 16);
    endtask

    task automatic sweep;
        for (int a = 0; a < DEP; a++) begin
            app_rd = '1;
            for (int b = 0; b < NB; b++) app_raddr[b*DN +: DN] = DN'(a);
            step;
            app_rd = '0;
            for (int b = 0; b < NB; b++) begin
                chk($sformatf("sweep_ack b%0d a%0d", b, a), P'(app_ack[b]), 1);
                chk($sformatf("sweep_data b%0d a%0d", b, a), P'(app_rdata[b*W +: W]), P'(mdl[b][a]));
            end
        end
    endtask

    task automatic app_read(input int b, input int a);
        app_rd = '0;
        app_rd[b] = 1'b1;
        app_raddr[b*DN +: DN] = DN'(a);
        step;
        app_rd = '0;
        chk($sformatf("app_ack b%0d", b), P'(app_ack), P'(1 << b));
        chk($sformatf("app_data b%0d a%0d", b, a), P'(app_rdata[b*W +: W]), P'(mdl[b][a]));
    endtask

    task automatic pio_write(input logic [NB-1:0] ms, input int a, input logic [W-1:0] d);
        reg_wr = 1'b1;
        reg_ms = ms;
        reg_addr = baddr(a);
        reg_din = {16'hDEAD, d};
        step;
        reg_wr = 1'b0;
        reg_ms = '0;
        for (int b = 0; b < NB; b++) if (ms[b]) mdl[b][a] = d;
    endtask

    task automatic pio_read(input int b, input int a);
        int n = 0;
        reg_rd = 1'b1;
        reg_ms = NB'(1 << b);
        reg_addr = baddr(a);
        step;
        reg_rd = 1'b0;
        reg_ms = '0;
        while (!mem_ack[b] && n < 10) begin
            step;
            n++;
        end
        chk($sformatf("pio_lat b%0d", b), n, 1);
        chk($sformatf("pio_data b%0d a%0d", b, a), mem_rdata[b*P +: P], P'(mdl[b][a]));
    endtask

    initial begin
        clr_model;
        #12;
        chk("rst_outs", P'({app_ack, mem_ack, init_done}), '0);
        chk("rst_rdata", P'(|{app_rdata, mem_rdata}), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init;
        sweep;
        // Single-bank write must not leak into a neighbour.
        pio_write(8'h08, 5, 16'h1234);
        step;
        app_read(3, 5);
        app_read(2, 5);
        // Read issued the cycle after the write strobe is served from the write stage.
        pio_write(8'h01, 7, 16'hBEEF);
        app_read(0, 7);
        // Held app reads starve a PIO read for exactly PIO_MAX_WAIT cycles.
        app_rd = 8'h01;
        app_raddr[0 +: DN] = 4'd3;
        reg_rd = 1'b1;
        reg_ms = 8'h01;
        reg_addr = baddr(7);
        for (int k = 1; k <= 7; k++) begin
            step;
            reg_rd = 1'b0;
            reg_ms = '0;
            chk($sformatf("starve_app_ack k%0d", k), P'(app_ack[0]), P'(k != 6));
            chk($sformatf("starve_mem_ack k%0d", k), P'(mem_ack[0]), P'(k == 6));
            if (k == 6) chk("starve_mem_data", mem_rdata[0 +: P], P'(mdl[0][7]));
            else        chk($sformatf("starve_app_data k%0d", k), P'(app_rdata[0 +: W]), P'(mdl[0][3]));
        end
        app_rd = '0;
        step;
        pio_write(8'hFF, 2, 16'h0055);
        step;
        for (int b = 0; b < NB; b++) app_read(b, 2);
        for (int i = 0; i < 60; i++) begin
            int b, a;
            b = int'($urandom % NB);
            a = int'($urandom % DEP);
            case ($urandom % 3)
                0: begin
                    pio_write(NB'($urandom) | NB'(1 << b), a, W'($urandom));
                    app_read(b, a);
                end
                1: app_read(b, a);
                default: pio_read(b, a);
            endcase
        end
        // Reset with a PIO read stuck behind app traffic on bank 1.
        pio_write(8'h02, 9, 16'hA5A5);
        app_rd = 8'h02;
        app_raddr[DN +: DN] = 4'd0;
        reg_rd = 1'b1;
        reg_ms = 8'h02;
        reg_addr = baddr(9);
        step;
        reg_rd = 1'b0;
        reg_ms = '0;
        step;
        chk("pend_no_ack", P'(mem_ack[1]), 0);
        rst_n = 1'b0;
        app_rd = '0;
        #1;
        chk("midrst_init_done", P'(init_done), 0);
        chk("midrst_acks", P'({app_ack, mem_ack}), 0);
        for (int k = 0; k < 3; k++) begin
            step;
            chk("midrst_hold_acks", P'({app_ack, mem_ack}), 0);
        end
        rst_n = 1'b1;
        clr_model;
        wait_init;
        sweep;
        pio_read(1, 9);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
